// File: rtl/spi_flash_xip_apb.sv
// spi_flash_xip_apb: APB read port that fetches 32-bit words from a SPI NOR
// flash with a single READ_CMD frame (8-bit opcode, 24-bit address, 32 data bits).
// Optional one-word read buffer enabled by the macro SPI_FLASH_XIP_PREFETCH_EN.
// APB handshake: an access is accepted in IDLE when in_psel && in_penable;
// in_pready is high for exactly one cycle (RESP) and in_prdata/in_pslverr are
// only meaningful (and non-zero) in that cycle; the master must drop in_psel
// or in_penable by the edge that ends RESP, otherwise a new access starts.
// The FSM state is held in state_q for observation.
`timescale 1ns/1ps
module spi_flash_xip_apb #(
    parameter int unsigned ADDR_BITS = 24,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned SS_NUM    = 8,
    parameter int unsigned SS_IDX    = 0,
    parameter logic [7:0]  READ_CMD  = 8'h03
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic              in_pwrite,
    input  logic [31:0]       in_pwdata,
    input  logic [3:0]        in_pstrb,
    output logic              in_pready,
    output logic [31:0]       in_prdata,
    output logic              in_pslverr,
    output logic              spi_sck,
    output logic [SS_NUM-1:0] spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t         state_q;
    state_t         state_d;
    logic [7:0]     div_q;
    logic [5:0]     bit_q;
    logic           sck_q;
    logic           mosi_q;
    logic [63:0]    tx_q;
    logic [31:0]    rx_q;
    logic [31:0]    resp_data_q;
    logic           err_q;

    logic           access;
    logic           half_done;
    logic           frame_end;
    logic           pf_hit;
    logic [31:0]    pf_word;
    logic [31:0]    rx_word;
    logic [ADDR_BITS-1:0] addr_aligned;
    logic [23:0]    addr24;
    logic [63:0]    frame;
    logic           unused_ok;

    // Write data, strobes and address bits above the flash range are ignored.
    assign unused_ok = ^{in_pwdata, in_pstrb, in_paddr};

    assign access       = in_psel && in_penable;
    assign half_done    = (state_q == SHIFT) && (div_q == DIV_LAST);
    assign frame_end    = half_done && sck_q && (bit_q == 6'd63);
    assign addr_aligned = {in_paddr[ADDR_BITS-1:2], 2'b00};
    assign addr24       = 24'(addr_aligned);
    assign frame        = {READ_CMD, addr24, 32'h0};
    // Bytes arrive MSB-first; the first byte received is the lowest-addressed one.
    assign rx_word      = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};

`ifdef SPI_FLASH_XIP_PREFETCH_EN
    logic                 pf_valid_q;
    logic [ADDR_BITS-3:0] pf_tag_q;
    logic [31:0]          pf_data_q;
    logic [ADDR_BITS-3:0] tag_q;

    assign pf_hit  = pf_valid_q && (pf_tag_q == in_paddr[ADDR_BITS-1:2]);
    assign pf_word = pf_data_q;

    // Read buffer: remember the tag of a missing read and refill at frame end.
    always_ff @(posedge clock) begin
        if (reset) begin
            pf_valid_q <= 1'b0;
            pf_tag_q   <= '0;
            pf_data_q  <= '0;
            tag_q      <= '0;
        end else begin
            if (state_q == IDLE && access && !in_pwrite && !pf_hit) begin
                tag_q <= in_paddr[ADDR_BITS-1:2];
            end
            if (frame_end) begin
                pf_valid_q <= 1'b1;
                pf_tag_q   <= tag_q;
                pf_data_q  <= rx_word;
            end
        end
    end
`else
    assign pf_hit  = 1'b0;
    assign pf_word = '0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: writes and buffer hits answer at once, reads shift a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = (in_pwrite || pf_hit) ? RESP : SHIFT;
                end
            end
            SHIFT: begin
                if (frame_end) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SPI datapath: half-period divider, SCK toggle, MOSI shift-out, MISO capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_q       <= '0;
            bit_q       <= '0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_q <= '0;
                    bit_q <= '0;
                    sck_q <= 1'b0;
                    if (access) begin
                        if (in_pwrite) begin
                            err_q       <= 1'b1;
                            resp_data_q <= '0;
                        end else if (pf_hit) begin
                            err_q       <= 1'b0;
                            resp_data_q <= pf_word;
                        end else begin
                            err_q  <= 1'b0;
                            mosi_q <= frame[63];
                            tx_q   <= {frame[62:0], 1'b0};
                        end
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            if (bit_q[5]) begin
                                rx_q <= {rx_q[30:0], spi_miso};
                            end
                        end else begin
                            sck_q <= 1'b0;
                            if (frame_end) begin
                                bit_q       <= '0;
                                mosi_q      <= 1'b0;
                                resp_data_q <= rx_word;
                            end else begin
                                bit_q  <= bit_q + 6'd1;
                                mosi_q <= tx_q[63];
                                tx_q   <= {tx_q[62:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: begin
                    div_q <= '0;
                    sck_q <= 1'b0;
                end
            endcase
        end
    end

    // Only the selected slave-select bit is ever driven low, and only while shifting.
    always_comb begin
        spi_ss = '1;
        if (state_q == SHIFT) begin
            spi_ss[SS_IDX] = 1'b0;
        end
    end

    assign spi_sck    = sck_q;
    assign spi_mosi   = mosi_q;
    assign in_pready  = (state_q == RESP);
    assign in_prdata  = (state_q == RESP) ? resp_data_q : 32'h0;
    assign in_pslverr = (state_q == RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_spi_flash_xip_apb.sv
// Testbench for spi_flash_xip_apb: flash model on the SPI pins, APB driver
// task with a reference model, and a monitor that scores every in_pready pulse.
`timescale 1ns/1ps
module tb_spi_flash_xip_apb;

    localparam int CLK_DIV   = 2;
    localparam int SS_NUM    = 8;
    localparam int SS_IDX    = 3;
    localparam int T         = 2 * CLK_DIV;
    localparam int FRAME_LAT = 1 + 64 * T;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [31:0]       in_paddr   = '0;
    logic              in_psel    = 1'b0;
    logic              in_penable = 1'b0;
    logic              in_pwrite  = 1'b0;
    logic [31:0]       in_pwdata  = '0;
    logic [3:0]        in_pstrb   = '0;
    logic              in_pready;
    logic [31:0]       in_prdata;
    logic              in_pslverr;
    logic              spi_sck;
    logic [SS_NUM-1:0] spi_ss;
    logic              spi_mosi;
    logic              spi_miso = 1'b0;

    spi_flash_xip_apb #(
        .ADDR_BITS(24),
        .CLK_DIV  (CLK_DIV),
        .SS_NUM   (SS_NUM),
        .SS_IDX   (SS_IDX),
        .READ_CMD (8'h03)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_paddr  (in_paddr),
        .in_psel   (in_psel),
        .in_penable(in_penable),
        .in_pwrite (in_pwrite),
        .in_pwdata (in_pwdata),
        .in_pstrb  (in_pstrb),
        .in_pready (in_pready),
        .in_prdata (in_prdata),
        .in_pslverr(in_pslverr),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [63:0] exp_frame_q[$];
    logic [7:0]  mem [0:4095];
    int          sck_rises = 0;
    logic        mon_en = 1'b0;
    logic        prev_pready = 1'b0;
    logic [32:0] mon_e;
    logic        pf_valid = 1'b0;
    logic [21:0] pf_tag = '0;
    logic [31:0] pf_data = '0;
    logic        ss_sel;

    assign ss_sel = spi_ss[SS_IDX];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference read: four consecutive flash bytes from the word-aligned address, little-endian.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        int base;
        base = int'(a & 32'h00FF_FFFC);
        return {mem[(base + 3) & 4095], mem[(base + 2) & 4095],
                mem[(base + 1) & 4095], mem[base & 4095]};
    endfunction

    // ---------------- flash model ----------------
    int          bit_n   = 0;
    logic [63:0] cap     = '0;
    logic [23:0] fl_addr = '0;

    always @(posedge spi_sck) sck_rises++;

    // Capture MOSI on SCK rise; on deselect score a complete frame, drop a partial one.
    always @(posedge spi_sck or posedge ss_sel) begin
        if (ss_sel) begin
            if (bit_n == 64) begin
                if (exp_frame_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got 0x%0h expected no frame", cap);
                end else begin
                    check("mosi_frame", cap, exp_frame_q.pop_front());
                end
            end
            bit_n = 0;
            cap   = '0;
        end else begin
            cap = {cap[62:0], spi_mosi};
            bit_n++;
            if (bit_n == 32) fl_addr = cap[23:0];
        end
    end

    // Drive the next data bit after each SCK fall (mode 0).
    always @(negedge spi_sck) begin
        if (!ss_sel && bit_n >= 32 && bit_n < 64) begin
            int idx;
            logic [7:0] b;
            idx = bit_n - 32;
            b = mem[(int'(fl_addr) + idx / 8) & 4095];
            spi_miso = b[7 - (idx % 8)];
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (mon_en) begin
            check("ss_others_high", spi_ss | (SS_NUM'(1) << SS_IDX), {SS_NUM{1'b1}});
            if (in_pready) begin
                check("pready_one_cycle", prev_pready, 1'b0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pready: got prdata 0x%0h expected no response", in_prdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("prdata", in_prdata, mon_e[31:0]);
                    check("pslverr", in_pslverr, mon_e[32]);
                end
            end else begin
                check("quiet_outputs", {in_pslverr, in_prdata}, 33'h0);
            end
            prev_pready = in_pready;
        end
    end

    // ---------------- driver ----------------
    task automatic apb_access(input logic wr, input logic [31:0] addr, output logic [31:0] rdata);
        int exp_lat;
        int exp_sck;
        int k;
        int sck0;
        logic [31:0] exp_data;
        logic exp_err;
        logic hit;
        hit = 1'b0;
`ifdef SPI_FLASH_XIP_PREFETCH_EN
        hit = !wr && pf_valid && (pf_tag == addr[23:2]);
`endif
        if (wr) begin
            exp_lat = 1; exp_data = '0; exp_err = 1'b1; exp_sck = 0;
        end else if (hit) begin
            exp_lat = 1; exp_data = pf_data; exp_err = 1'b0; exp_sck = 0;
        end else begin
            exp_lat = FRAME_LAT; exp_data = model_read(addr); exp_err = 1'b0; exp_sck = 64;
            exp_frame_q.push_back({8'h03, addr[23:2], 2'b00, 32'h0});
            pf_valid = 1'b1;
            pf_tag   = addr[23:2];
            pf_data  = exp_data;
        end
        exp_q.push_back({exp_err, exp_data});
        sck0 = sck_rises;
        @(posedge clock); #1;
        in_psel = 1'b1; in_penable = 1'b0; in_pwrite = wr; in_paddr = addr;
        in_pwdata = $urandom; in_pstrb = 4'($urandom_range(0, 15));
        @(posedge clock); #1;
        in_penable = 1'b1;
        k = 0;
        do begin
            @(posedge clock); #1;
            k++;
        end while (!in_pready && k < 2000);
        rdata = in_prdata;
        in_psel = 1'b0; in_penable = 1'b0;
        check("pready_latency", k, exp_lat);
        check("sck_edges", sck_rises - sck0, exp_sck);
        check("ss_released_in_resp", spi_ss, {SS_NUM{1'b1}});
    endtask

    task automatic reset_mid_read(input logic [31:0] addr);
        int sck0;
        @(posedge clock); #1;
        in_psel = 1'b1; in_penable = 1'b0; in_pwrite = 1'b0; in_paddr = addr;
        @(posedge clock); #1;
        in_penable = 1'b1;
        repeat (40) @(posedge clock);
        #1 reset = 1'b1;
        in_psel = 1'b0; in_penable = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        pf_valid = 1'b0;
        check("rst_mid_ss", spi_ss, {SS_NUM{1'b1}});
        check("rst_mid_sck", spi_sck, 1'b0);
        check("rst_mid_mosi", spi_mosi, 1'b0);
        check("rst_mid_pready", in_pready, 1'b0);
        sck0 = sck_rises;
        repeat (300) @(posedge clock);
        #1 check("no_frame_resume", sck_rises - sck0, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        logic [31:0] last_addr;
        logic [31:0] a;
        int r;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        check("reset_ss", spi_ss, {SS_NUM{1'b1}});
        check("reset_sck", spi_sck, 1'b0);
        check("reset_mosi", spi_mosi, 1'b0);
        check("reset_pready", in_pready, 1'b0);

        apb_access(1'b0, 32'h3000_0100, d);
        check("directed_word", d, 32'h4433_2211);
        apb_access(1'b0, 32'h3000_0102, d);
        check("directed_unaligned", d, 32'h4433_2211);
        apb_access(1'b1, 32'h3000_0000, d);
        check("directed_write_data", d, 32'h0);

        reset_mid_read(32'h3000_0200);

        apb_access(1'b0, 32'h3000_0100, d);
        apb_access(1'b0, 32'h3000_0100, d);
        check("repeat_word", d, 32'h4433_2211);
        apb_access(1'b0, 32'h3000_0104, d);
        last_addr = 32'h3000_0104;

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                a = 32'h3000_0000 | 32'($urandom_range(0, 16'hFFFF));
                apb_access(1'b1, a, d);
            end else begin
                if (r < 5) a = {last_addr[31:2], 2'($urandom_range(0, 3))};
                else       a = {8'h30, 24'($urandom)};
                apb_access(1'b0, a, d);
                last_addr = a;
            end
        end

        repeat (5) @(posedge clock);
        #1;
        check("responses_drained", exp_q.size(), 0);
        check("frames_drained", exp_frame_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
